if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage with a decoupled prefetch queue. It replaces the single-entry IF/ID register with an in-order request/response instruction-memory interface and an `FQ_DEPTH`-entry instruction queue. It tolerates variable memory latency and discards in-flight responses on redirect or flush. It sits between the instruction memory and the ID stage, and ID consumes it as the IF/ID register.

## Interface
- `XLEN`, 32: PC and instruction width.
- `FQ_DEPTH`, 4: queue entries; a power of two, at least 2.
- `RESET_PC`, 32'h00000000: fetch PC after reset.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  ID cannot accept this cycle; hold the head entry.
- `flush`  in  1  kill queue and in-flight fetches, then halt fetching.
- `pc_src`  in  1  redirect; kill queue and in-flight fetches, then restart at `new_pc`.
- `new_pc`  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  fetch address; equals the fetch PC.
- `imem_resp_valid`  in  1  response beat; in order, no backpressure.
- `imem_resp_data`  in  XLEN  fetched instruction.
- `if_id_valid`  out  1  queue head is valid.
- `if_id_pc`  out  XLEN  PC of the head entry; 0 when invalid.
- `if_id_instruction`  out  XLEN  head instruction; NOP 32'h00000013 when invalid.

## Operation
- **State:** `fetch_pc`, `halted`, `outstanding` (0..FQ_DEPTH), `drop_cnt` (0..FQ_DEPTH), and a queue of {pc, instr} with `count`.
- **Issue:** `imem_req_valid = !halted && (count + outstanding) < FQ_DEPTH`.
  - Credit-based, so the queue can never overflow.
  - A handshake (`valid && ready`) sets `fetch_pc += 4` (mod 2^XLEN wrap) and increments `outstanding`.
- **PC tag:** the PC of each issued request goes into a small in-order tag queue of depth FQ_DEPTH. It is paired with the matching response.
- **Response:**
  - If `drop_cnt > 0`: decrement `drop_cnt` and discard the beat.
  - Otherwise: push {tag pc, data} into the queue.
  - In both cases, decrement `outstanding` and pop the tag.
- **Pop:** `if_id_valid && !stall` removes the head.
- **`pc_src` (priority over `flush`):**
  - Clear the queue and set `fetch_pc = {new_pc[XLEN-1:2], 2'b00}`.
  - Clear `halted`.
  - Set `drop_cnt = outstanding_next`. This includes a request accepted in the same cycle, minus a response consumed in the same cycle.
- **`flush` without `pc_src`:** same kill and drop behaviour, but set `halted = 1` and leave `fetch_pc` unchanged. Fetching resumes only on a later `pc_src`.
- **Same-cycle events:**
  - A pop in a kill cycle is ignored; the queue is cleared regardless.
  - A response in a kill cycle is dropped, not pushed.
  - Push and pop in the same cycle leave `count` unchanged.
- **`reset`:**
  - Sets `fetch_pc = RESET_PC`, `halted = 0`, queue empty, `outstanding = 0`, `drop_cnt = 0`.
  - Outputs: `if_id_valid = 0`, `if_id_pc = 0`, `if_id_instruction = 32'h00000013`, `imem_req_valid = 0` during the reset cycle.
  - Mid-operation reset abandons in-flight requests. The memory is reset by the same `reset`, so there is no draining.

## Timing
- `imem_req_valid` and `imem_req_addr` are combinational from registers only. There is no combinational path from `imem_req_ready`.
- Latency: a response in cycle N shows `if_id_valid` in cycle N+1, provided the queue was empty and nothing was dropped.
- With zero-wait memory (response one cycle after the handshake), the steady-state throughput is one instruction per cycle.
- The kill takes effect at the edge ending the `pc_src` / `flush` cycle. The first request to `new_pc` may issue in the following cycle.
- `if_id_*` are driven from the queue storage registers through the valid/NOP mux. They hold stable while `stall` is high.

## Structure
- Shared package `riscv_pkg` holds `NOP_INSTR` = 32'h00000013 and the `XLEN` default.
- Sub-module `fetch_fifo`: a synchronous show-ahead FIFO.
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: push, pop, clear, full, empty, count.
  - It is instantiated twice: once for the instruction queue with width 2·XLEN, and once for the PC tag queue with width XLEN.
- Required assertions: no push when full; `outstanding` never exceeds FQ_DEPTH; `drop_cnt` ≤ `outstanding`.

## Test plan
- **Reset:** hold `reset` for 2 cycles -> `if_id_valid = 0`, `if_id_instruction = 0x00000013`, `imem_req_addr = RESET_PC`. The first request issues in the cycle after reset is released.
- **Zero-wait stream:** `ready = 1`, response one cycle after the handshake, `stall = 0` -> PCs 0, 4, 8, 12 appear on consecutive cycles with matching data.
- **Backpressure:** hold `stall = 1` for 10 cycles with FQ_DEPTH = 4 -> exactly 4 entries queued and `imem_req_valid = 0`. Head PC 0 stays stable. On release, 0, 4, 8, 12 drain in order.
- **Redirect with in-flight fetches:** 2 requests outstanding (latency 3), `pc_src = 1`, `new_pc = 0x103` -> both late responses are discarded. The next request address is 0x100, and the first valid output is pc 0x100.
- **Flush, then combined kill:** `flush` alone -> queue empty and no requests for 5 cycles. Then `pc_src` and `flush` together with `new_pc = 0x200` -> fetch resumes at 0x200.
- **Reset mid-operation:** assert `reset` with 3 queued entries and 1 outstanding -> all outputs return to reset values next cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used by the fetch stage and its queues.
package riscv_pkg;

   localparam int          XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO: the oldest entry is always visible on head_data.
module fetch_fifo import riscv_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     clear,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      cnt;
   logic             do_pop;

   assign do_pop    = pop && !empty;
   assign full      = (cnt == (AW+1)'(DEPTH));
   assign empty     = (cnt == '0);
   assign count     = cnt;
   assign head_data = mem[rd_ptr];

   // Storage array; written only on a live push, never reset.
   always_ff @(posedge clk) begin
      if (push && !clear && !reset) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; clear empties the FIFO in one edge.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Callers must never push into a full FIFO.
   assert property (@(posedge clk) disable iff (reset) !(push && !clear && full));

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: credit-limited in-order memory requests feeding a
// prefetch queue that ID reads as its IF/ID register.
module if_fetch_queue import riscv_pkg::*; #(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              FQ_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            pc_src,
   input  logic [XLEN-1:0] new_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_instruction
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   logic [XLEN-1:0]   fetch_pc;
   logic              halted;
   logic [CW-1:0]     drop_cnt;

   logic [CW-1:0]     q_count;
   logic              q_full;
   logic              q_empty;
   logic [2*XLEN-1:0] q_head;
   logic [CW-1:0]     tag_count;
   logic              tag_full;
   logic              tag_empty;
   logic [XLEN-1:0]   tag_head;

   logic              kill;
   logic              req_fire;
   logic              resp_drop;
   logic              q_push;
   logic              q_pop;
   logic [CW:0]       credit_used;
   logic [CW-1:0]     outstanding_next;

   // The tag FIFO occupancy is the number of requests still awaiting a response.
   assign kill             = pc_src || flush;
   assign credit_used      = {1'b0, q_count} + {1'b0, tag_count};
   assign imem_req_valid   = !reset && !halted && (credit_used < (CW+1)'(FQ_DEPTH));
   assign imem_req_addr    = fetch_pc;
   assign req_fire         = imem_req_valid && imem_req_ready;
   assign resp_drop        = (drop_cnt != '0);
   assign q_push           = imem_resp_valid && !resp_drop && !kill;
   assign q_pop            = !q_empty && !stall && !kill;
   assign outstanding_next = tag_count + CW'(req_fire) - CW'(imem_resp_valid);

   assign if_id_valid       = !reset && !q_empty;
   assign if_id_pc          = if_id_valid ? q_head[2*XLEN-1:XLEN] : '0;
   assign if_id_instruction = if_id_valid ? q_head[XLEN-1:0] : XLEN'(NOP_INSTR);

   fetch_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (FQ_DEPTH)
   ) u_instr_q (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data ({tag_head, imem_resp_data}),
      .pop       (q_pop),
      .clear     (kill),
      .head_data (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (FQ_DEPTH)
   ) u_tag_q (
      .clk       (clk),
      .reset     (reset),
      .push      (req_fire),
      .push_data (fetch_pc),
      .pop       (imem_resp_valid),
      .clear     (1'b0),
      .head_data (tag_head),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (tag_count)
   );

   // Fetch PC, halt flag and the count of stale responses still to be discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         halted   <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (pc_src) begin
            fetch_pc <= new_pc & ~XLEN'(3);
            halted   <= 1'b0;
         end else begin
            if (flush) begin
               halted <= 1'b1;
            end
            if (req_fire) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end
         end
         if (kill) begin
            drop_cnt <= outstanding_next;
         end else if (imem_resp_valid && resp_drop) begin
            drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   assert property (@(posedge clk) disable iff (reset) tag_count <= CW'(FQ_DEPTH));
   assert property (@(posedge clk) disable iff (reset) drop_cnt <= tag_count);
   assert property (@(posedge clk) disable iff (reset) !(q_push && q_full));
   assert property (@(posedge clk) disable iff (reset) !(req_fire && tag_full));
   assert property (@(posedge clk) disable iff (reset) !(imem_resp_valid && tag_empty));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised scoreboard bench for if_fetch_queue with an in-order memory model.
module tb_if_fetch_queue;

   localparam int          FQ_DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] new_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;

   typedef struct {
      int          due;
      logic [31:0] pc;
      logic [31:0] data;
      int          epoch;
   } mem_req_t;

   mem_req_t    mem_q[$];
   mem_req_t    cur_resp;
   logic [63:0] sb[$];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          ready_pct = 100;
   int          consumed = 0;

   int          epoch = 0;
   int          inflight = 0;
   int          last_due = 0;
   bit          halted_m = 1'b0;
   logic [31:0] exp_addr = RESET_PC;

   always #5 clk = ~clk;

   if_fetch_queue #(
      .XLEN     (32),
      .FQ_DEPTH (FQ_DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .flush             (flush),
      .pc_src            (pc_src),
      .new_pc            (new_pc),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_req_addr     (imem_req_addr),
      .imem_resp_valid   (imem_resp_valid),
      .imem_resp_data    (imem_resp_data),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock of input drive; the memory model answers due requests in order.
   task automatic driveCycle(input bit rst, input bit st, input bit ps, input bit fl,
                             input logic [31:0] np);
      @(posedge clk);
      #1;
      cyc++;
      reset  = rst;
      stall  = st;
      pc_src = ps;
      flush  = fl;
      new_pc = np;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         cur_resp        = mem_q.pop_front();
         imem_resp_valid = 1'b1;
         imem_resp_data  = cur_resp.data;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
   endtask

   task automatic applyStimulus(input int n, input int stall_pct, input int kill_pct);
      logic [31:0] np;
      bit ps;
      bit fl;
      for (int i = 0; i < n; i++) begin
         np = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         ps = ($urandom_range(99) < kill_pct);
         fl = ($urandom_range(99) < kill_pct);
         driveCycle(1'b0, ($urandom_range(99) < stall_pct), ps, fl, np);
      end
   endtask

   // Monitor: compares the DUT against the queue model, then advances the model.
   initial begin
      bit          kill;
      bit          hs;
      bit          resp_live;
      bit          exp_rv;
      int          due;
      forever begin
         @(negedge clk);
         if (reset) begin
            checkOutput("rst_if_valid", 32'(if_id_valid), 32'd0);
            checkOutput("rst_if_pc", if_id_pc, 32'd0);
            checkOutput("rst_if_instr", if_id_instruction, NOP);
            checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
            sb.delete();
            mem_q.delete();
            inflight = 0;
            last_due = 0;
            halted_m = 1'b0;
            exp_addr = RESET_PC;
            epoch++;
         end else begin
            exp_rv = !halted_m && ((sb.size() + inflight) < FQ_DEPTH);
            checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (imem_req_valid) begin
               checkOutput("req_addr", imem_req_addr, exp_addr);
            end
            if (sb.size() > 0) begin
               checkOutput("if_valid", 32'(if_id_valid), 32'd1);
               checkOutput("if_pc", if_id_pc, sb[0][63:32]);
               checkOutput("if_instr", if_id_instruction, sb[0][31:0]);
            end else begin
               checkOutput("if_valid", 32'(if_id_valid), 32'd0);
               checkOutput("if_pc_idle", if_id_pc, 32'd0);
               checkOutput("if_instr_idle", if_id_instruction, NOP);
            end

            kill      = pc_src || flush;
            hs        = imem_req_valid && imem_req_ready;
            resp_live = 1'b0;
            if (hs) begin
               due = cyc + $urandom_range(lat_max, lat_min);
               if (due <= last_due) begin
                  due = last_due + 1;
               end
               last_due = due;
               mem_q.push_back('{due, exp_addr, $urandom, epoch});
               inflight++;
            end
            if (imem_resp_valid) begin
               inflight--;
               resp_live = (cur_resp.epoch == epoch) && !kill;
            end
            if (kill) begin
               sb.delete();
               epoch++;
               if (pc_src) begin
                  halted_m = 1'b0;
                  exp_addr = new_pc & ~32'd3;
               end else begin
                  halted_m = 1'b1;
                  if (hs) exp_addr = exp_addr + 32'd4;
               end
            end else begin
               if (sb.size() > 0 && !stall) begin
                  void'(sb.pop_front());
                  consumed++;
               end
               if (resp_live) begin
                  sb.push_back({cur_resp.pc, cur_resp.data});
               end
               if (hs) exp_addr = exp_addr + 32'd4;
            end
         end
      end
   end

   // Directed scenarios followed by randomised traffic.
   initial begin
      driveCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      driveCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

      ready_pct = 100; lat_min = 1; lat_max = 1;
      applyStimulus(12, 0, 0);

      applyStimulus(10, 100, 0);
      applyStimulus(8, 0, 0);

      lat_min = 3; lat_max = 3;
      applyStimulus(2, 0, 0);
      driveCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0103);
      applyStimulus(10, 0, 0);

      lat_min = 1; lat_max = 2;
      driveCycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      applyStimulus(5, 0, 0);
      driveCycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
      applyStimulus(10, 0, 0);

      driveCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF6);
      applyStimulus(10, 20, 0);

      lat_min = 1; lat_max = 4; ready_pct = 70;
      applyStimulus(1500, 30, 3);

      lat_min = 2; lat_max = 2; ready_pct = 100;
      applyStimulus(4, 100, 0);
      driveCycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(10, 0, 0);

      lat_min = 1; lat_max = 3; ready_pct = 80;
      applyStimulus(800, 25, 2);
      applyStimulus(20, 0, 0);

      checkOutput("progress", 32'(consumed > 200), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
